// File: rtl/ddr_resp_bram.sv
// Single-port 512-bit line memory answering DDR-style read/write strobes.
// One request in flight at a time; reads respond after RD_LATENCY cycles (legal range 2..15).
module ddr_resp_bram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_LSB   = 6,
    parameter int RD_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         DDR_en_i,
    input  logic         DDR_en_wr_i,
    input  logic [31:0]  DDR_adr_i,
    input  logic [511:0] DDR_in_i,
    output logic         ddr_en_o,
    output logic         DDR_valid_o,
    output logic [511:0] DDR_out_o,
    output logic         addr_err_o,
    output logic         req_drop_o
);

    localparam int          LINES     = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = 4'(RD_LATENCY - 2);
    localparam logic [31:0] HIGH_MASK = 32'hFFFF_FFFF << (ADDR_LSB + DEPTH_LOG2);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             waitCnt_q, waitCnt_d;
    logic [DEPTH_LOG2-1:0]  rdIdx_q;
    logic [DEPTH_LOG2-1:0]  reqIdx;
    logic                   ready_q;
    logic                   accept;
    logic                   addrHigh;
    logic [511:0]           out_q;
    logic                   addrErr_q;
    logic                   reqDrop_q;
    logic [511:0]           mem [LINES];

    assign reqIdx   = DDR_adr_i[ADDR_LSB +: DEPTH_LOG2];
    assign addrHigh = |(DDR_adr_i & HIGH_MASK);
    assign accept   = DDR_en_i & ready_q;

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (DDR_en_wr_i) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = RD_WAIT;
                        waitCnt_d = WAIT_INIT;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RD_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ready is registered so it stays low during reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            ready_q   <= 1'b0;
            rdIdx_q   <= '0;
            out_q     <= '0;
            addrErr_q <= 1'b0;
            reqDrop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            ready_q   <= (state_d == IDLE);
            if (accept) begin
                rdIdx_q <= reqIdx;
            end
            if (state_d == RESP) begin
                out_q <= mem[rdIdx_q];
            end
            addrErr_q <= addrErr_q | (accept & addrHigh);
            reqDrop_q <= reqDrop_q | (DDR_en_i & ~ready_q);
        end
    end

    // Memory contents survive reset, so this array has no reset branch
    always_ff @(posedge clk) begin
        if (accept && DDR_en_wr_i) begin
            mem[reqIdx] <= DDR_in_i;
        end
    end

    assign ddr_en_o    = ready_q;
    assign DDR_valid_o = (state_q == RESP);
    assign DDR_out_o   = out_q;
    assign addr_err_o  = addrErr_q;
    assign req_drop_o  = reqDrop_q;

endmodule

// File: tb/tb_ddr_resp_bram.sv
// Directed and random bench for ddr_resp_bram; instance 0 uses the default latency,
// instances 1 and 2 share its inputs and run at latency 2 and 15.
module tb_ddr_resp_bram;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         DDR_en = 1'b0;
    logic         DDR_en_wr = 1'b0;
    logic [31:0]  DDR_adr = '0;
    logic [511:0] DDR_in = '0;

    logic         ddrEn   [3];
    logic         valid   [3];
    logic [511:0] dout    [3];
    logic         addrErr [3];
    logic         reqDrop [3];

    int           total = 0;
    int           bad = 0;
    int           validSeen = 0;
    int           readsIssued = 0;
    logic [511:0] expQ [$];
    logic [511:0] model [256];
    bit           written [256];

    always #5 clk = ~clk;

    ddr_resp_bram dut (
        .clk(clk), .rst_n(rst_n), .DDR_en_i(DDR_en), .DDR_en_wr_i(DDR_en_wr),
        .DDR_adr_i(DDR_adr), .DDR_in_i(DDR_in), .ddr_en_o(ddrEn[0]),
        .DDR_valid_o(valid[0]), .DDR_out_o(dout[0]), .addr_err_o(addrErr[0]),
        .req_drop_o(reqDrop[0])
    );

    ddr_resp_bram #(.RD_LATENCY(2)) dutFast (
        .clk(clk), .rst_n(rst_n), .DDR_en_i(DDR_en), .DDR_en_wr_i(DDR_en_wr),
        .DDR_adr_i(DDR_adr), .DDR_in_i(DDR_in), .ddr_en_o(ddrEn[1]),
        .DDR_valid_o(valid[1]), .DDR_out_o(dout[1]), .addr_err_o(addrErr[1]),
        .req_drop_o(reqDrop[1])
    );

    ddr_resp_bram #(.RD_LATENCY(15)) dutSlow (
        .clk(clk), .rst_n(rst_n), .DDR_en_i(DDR_en), .DDR_en_wr_i(DDR_en_wr),
        .DDR_adr_i(DDR_adr), .DDR_in_i(DDR_in), .ddr_en_o(ddrEn[2]),
        .DDR_valid_o(valid[2]), .DDR_out_o(dout[2]), .addr_err_o(addrErr[2]),
        .req_drop_o(reqDrop[2])
    );

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputInt(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] randLine();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int idxOf(input logic [31:0] adr);
        return int'(adr[13:6]);
    endfunction

    // Scoreboard: every read pulse on instance 0 must match the oldest expected line
    always @(negedge clk) begin
        if (valid[0] === 1'b1) begin
            validSeen++;
            if (expQ.size() == 0) begin
                checkOutputInt("unexpected_valid", int'(valid[0]), 0);
            end else begin
                checkOutput("read_data", dout[0], expQ.pop_front());
            end
        end
    end

    task automatic waitReady();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ddrEn[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutputInt("ready_timeout", int'(ddrEn[0]), 1);
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] adr, input logic [511:0] data);
        waitReady();
        DDR_en = 1'b1;
        DDR_en_wr = wr;
        DDR_adr = adr;
        DDR_in = data;
        @(posedge clk);
        #1;
        DDR_en = 1'b0;
        DDR_en_wr = ~wr;
        DDR_in = randLine();
    endtask

    task automatic writeLine(input logic [31:0] adr, input logic [511:0] data);
        model[idxOf(adr)] = data;
        written[idxOf(adr)] = 1'b1;
        applyStimulus(1'b1, adr, data);
        @(negedge clk);
        checkOutputInt("wr_busy", int'(ddrEn[0]), 0);
        @(negedge clk);
        checkOutputInt("wr_ready", int'(ddrEn[0]), 1);
    endtask

    task automatic readLine(input logic [31:0] adr);
        logic [511:0] exp;
        int lat = 0;
        bit busyHigh = 1'b0;
        exp = model[idxOf(adr)];
        expQ.push_back(exp);
        readsIssued++;
        applyStimulus(1'b0, adr, ~exp);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (valid[0] === 1'b1) begin
                lat = k;
                break;
            end
            if (ddrEn[0] !== 1'b0) busyHigh = 1'b1;
        end
        checkOutputInt("rd_latency", lat, 4);
        checkOutputInt("rd_busy_during_wait", int'(busyHigh), 0);
        @(negedge clk);
        checkOutputInt("rd_ready_after", int'(ddrEn[0]), 1);
        checkOutput("rd_out_hold", dout[0], exp);
    endtask

    initial begin
        int acc;
        int cyc;
        int lat [3];
        logic [511:0 ] got [3];
        logic [511:0] pat;
        bit slowBusy;
        int line;

        // Reset values
        @(negedge clk);
        checkOutputInt("rst_ddr_en", int'(ddrEn[0]), 0);
        checkOutputInt("rst_valid", int'(valid[0]), 0);
        checkOutput("rst_out", dout[0], '0);
        checkOutputInt("rst_addr_err", int'(addrErr[0]), 0);
        checkOutputInt("rst_req_drop", int'(reqDrop[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutputInt("release_ddr_en_low", int'(ddrEn[0]), 0);
        @(negedge clk);
        checkOutputInt("release_ddr_en_high", int'(ddrEn[0]), 1);

        // Write line 3 then read it back in the first idle cycle
        writeLine(32'h0000_00C0, {64{8'hA5}});
        readLine(32'h0000_00C0);
        checkOutputInt("no_addr_err_yet", int'(addrErr[0]), 0);
        checkOutputInt("no_req_drop_yet", int'(reqDrop[0]), 0);

        // High address bits set: flagged but the access wraps to line 1
        pat = randLine();
        writeLine(32'h0000_4040, pat);
        checkOutputInt("addr_err_set", int'(addrErr[0]), 1);
        readLine(32'h0000_0040);

        // Strobe held high across ten writes: only idle-cycle strobes land
        waitReady();
        DDR_en = 1'b1;
        DDR_en_wr = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 10 && cyc < 40) begin
            DDR_in = randLine();
            if (ddrEn[0] === 1'b1) begin
                DDR_adr = 32'h400 + 32'(acc) * 32'd64;
                model[idxOf(DDR_adr)] = DDR_in;
                written[idxOf(DDR_adr)] = 1'b1;
                acc++;
            end else begin
                DDR_adr = 32'h400 + 32'(acc - 1) * 32'd64;
            end
            @(negedge clk);
            cyc++;
        end
        DDR_en = 1'b0;
        checkOutputInt("b2b_accepted", acc, 10);
        checkOutputInt("b2b_cycles", cyc, 19);
        checkOutputInt("b2b_req_drop", int'(reqDrop[0]), 1);
        for (int i = 0; i < 10; i++) readLine(32'h400 + 32'(i) * 32'd64);

        // Reset two cycles into a read: no response, flags cleared, memory kept
        waitReady();
        DDR_en = 1'b1;
        DDR_en_wr = 1'b0;
        DDR_adr = 32'h0000_00C0;
        @(posedge clk);
        #1;
        DDR_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutputInt("pre_reset_addr_err", int'(addrErr[0]), 1);
        rst_n = 1'b0;
        #1;
        checkOutputInt("midrd_rst_ddr_en", int'(ddrEn[0]), 0);
        checkOutputInt("midrd_rst_valid", int'(valid[0]), 0);
        checkOutput("midrd_rst_out", dout[0], '0);
        checkOutputInt("midrd_rst_addr_err", int'(addrErr[0]), 0);
        checkOutputInt("midrd_rst_req_drop", int'(reqDrop[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutputInt("midrd_release_ready", int'(ddrEn[0]), 1);
        repeat (20) @(negedge clk);
        checkOutputInt("midrd_no_valid", validSeen, readsIssued);
        readLine(32'h0000_00C0);
        readLine(32'h0000_0440);

        // Latency 2 / 4 / 15 instances answer the same read
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) checkOutputInt("lat_ready", int'(ddrEn[i]), 1);
        pat = randLine();
        model[2] = pat;
        written[2] = 1'b1;
        DDR_en = 1'b1;
        DDR_en_wr = 1'b1;
        DDR_adr = 32'h80;
        DDR_in = pat;
        @(posedge clk);
        #1;
        DDR_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        DDR_en = 1'b1;
        DDR_en_wr = 1'b0;
        expQ.push_back(pat);
        readsIssued++;
        @(posedge clk);
        #1;
        DDR_en = 1'b0;
        lat = '{0, 0, 0};
        got = '{'0, '0, '0};
        slowBusy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (valid[i] === 1'b1 && lat[i] == 0) begin
                    lat[i] = k;
                    got[i] = dout[i];
                end
            end
            if (lat[2] == 0 && ddrEn[2] !== 1'b0) slowBusy = 1'b1;
        end
        checkOutputInt("lat_default", lat[0], 4);
        checkOutputInt("lat_min", lat[1], 2);
        checkOutputInt("lat_max", lat[2], 15);
        checkOutput("lat_min_data", got[1], pat);
        checkOutput("lat_max_data", got[2], pat);
        checkOutputInt("lat_max_busy", int'(slowBusy), 0);

        // Random mix against the line model
        for (int n = 0; n < 1000; n++) begin
            line = $urandom_range(0, 31);
            if (!written[line] || $urandom_range(0, 1) == 1)
                writeLine(32'(line) * 32'd64 + 32'($urandom_range(0, 63)), randLine());
            else
                readLine(32'(line) * 32'd64 + 32'($urandom_range(0, 63)));
        end

        repeat (10) @(negedge clk);
        checkOutputInt("queue_drained", expQ.size(), 0);
        checkOutputInt("one_valid_per_read", validSeen, readsIssued);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_resp_bram.md
DDR_RESP_BRAM -- requirements
Module: ddr_resp_bram

Interface
Parameters:
REQ-001 DEPTH_LOG2, default 8, SHALL set the number of 512-bit memory lines to 2**DEPTH_LOG2.
REQ-002 ADDR_LSB, default 6, SHALL set the DDR_adr bit at which the line index starts (byte address, 64-byte lines).
REQ-003 RD_LATENCY, default 4, legal range 2..15, SHALL set the cycle count from an accepted read to DDR_valid.

Ports:
REQ-004 clk  in  1  single clock for all logic (150 MHz domain).
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 DDR_en  in  1  request strobe from the initiator.
REQ-007 DDR_en_wr  in  1  request type: 1 is write, 0 is read; qualified by DDR_en.
REQ-008 DDR_adr  in  32  request byte address.
REQ-009 DDR_in  in  512  write data.
REQ-010 ddr_en  out  1  responder ready.
REQ-011 DDR_valid  out  1  one-cycle read-data-valid pulse.
REQ-012 DDR_out  out  512  read data.
REQ-013 addr_err  out  1  sticky flag: an accepted address had nonzero bits above the line index.
REQ-014 req_drop  out  1  sticky flag: DDR_en was seen while ddr_en was 0.

Function
REQ-015 The block SHALL hold a memory of 2**DEPTH_LOG2 x 512 bits, indexed by idx = DDR_adr[ADDR_LSB +: DEPTH_LOG2]; DDR_adr bits below ADDR_LSB SHALL be ignored.
REQ-016 The FSM SHALL have exactly four states: IDLE, WRITE, RD_WAIT, RESP.
REQ-017 ddr_en SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted only on an edge where DDR_en=1 and ddr_en=1; call that edge cycle T.
REQ-019 Accepted write: mem[idx] SHALL take DDR_in at edge T; the FSM SHALL go IDLE->WRITE->IDLE, so ddr_en is 0 in cycle T+1 and 1 again in cycle T+2.
REQ-020 Accepted read: the block SHALL register idx at T and go to RD_WAIT with a wait counter loaded with RD_LATENCY-2.
REQ-021 In RD_WAIT the counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to RESP.
REQ-022 In the RESP cycle (cycle T+RD_LATENCY), DDR_valid SHALL be 1 and DDR_out SHALL equal mem[idx]; the FSM SHALL then return to IDLE, so ddr_en is 1 in cycle T+RD_LATENCY+1.
REQ-023 DDR_valid SHALL be 1 for exactly one cycle per accepted read and SHALL be 0 at all other times.
REQ-024 DDR_out SHALL hold its last read value between DDR_valid pulses.
REQ-025 A read accepted at the first IDLE cycle after a write to the same idx SHALL return the newly written data.
REQ-026 DDR_en while ddr_en=0 SHALL be ignored: no memory update and no response; req_drop SHALL be set.
REQ-027 Address bits DDR_adr[31 : ADDR_LSB+DEPTH_LOG2] nonzero on an accepted request SHALL set addr_err; the access SHALL still proceed at the wrapped idx.
REQ-028 addr_err and req_drop SHALL clear only on reset.
REQ-029 DDR_en_wr and DDR_in SHALL be sampled only at acceptance; changes at any other time SHALL have no effect.

Reset
REQ-030 While rst_n=0, the block SHALL force: FSM=IDLE, ddr_en=0, DDR_valid=0, DDR_out=0, addr_err=0, req_drop=0, wait counter=0.
REQ-031 ddr_en SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset mid-read SHALL abort the read: no DDR_valid pulse after release.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-034 Write mem line 3 with DDR_adr=0x000000C0 and DDR_in={64{8'hA5}}, then read 0xC0 -> ddr_en is 0 for one cycle after the write; DDR_valid pulses exactly 4 cycles after read acceptance with DDR_out={64{8'hA5}}.
REQ-035 Back-to-back traffic: the initiator holds DDR_en=1 continuously for 10 writes -> only IDLE-cycle strobes are accepted (one every 2 cycles); req_drop=1; each written line reads back correctly.
REQ-036 DDR_adr=0x00004040 with defaults -> addr_err=1; the access hits line 1; a read of 0x40 returns the same data.
REQ-037 Assert rst_n=0 two cycles after read acceptance, release after 3 cycles -> no DDR_valid pulse; ddr_en=1 one cycle after release; previously written data is still readable.
REQ-038 Run with RD_LATENCY=2 and RD_LATENCY=15 -> DDR_valid appears at T+2 and T+15 respectively; ddr_en is 0 throughout the wait.
REQ-039 A random mix of 1000 reads and writes against a reference model -> every DDR_out matches; there is exactly one DDR_valid per accepted read.
